afe_pulser_burst: RTL and testbench
===================================

AFE_PULSER_BURST -- requirements
Module: afe_pulser_burst

Interface
REQ-001 Parameter N_CH, default 4: number of output channels (1..16).
REQ-002 Parameter W_BITS, default 16: width of the width and period fields.
REQ-003 Parameter N_BITS, default 8: width of the pulse-count field.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 trig  input  1  single-cycle start request.
REQ-007 abort  input  1  stops a running burst.
REQ-008 ch_mask  input  N_CH  channels that pulse in this burst.
REQ-009 y0  input  N_CH  per-channel idle level (polarity).
REQ-010 width  input  W_BITS  high time in clk cycles.
REQ-011 period  input  W_BITS  rising-edge spacing in clk cycles.
REQ-012 n_pulses  input  N_BITS  pulses per burst.
REQ-013 out  output  N_CH  registered pulse outputs.
REQ-014 busy  output  1  burst in progress.
REQ-015 done  output  1  one-cycle burst-complete strobe.
REQ-016 pulse_idx  output  N_BITS  pulses emitted in current or last burst.
REQ-017 stat_pulses  output  32  lifetime pulse count (macro-dependent).
REQ-018 stat_drops  output  16  lifetime ignored-trigger count (macro-dependent).

Function
REQ-019 FSM states: IDLE, HIGH, LOW; all outputs registered.
REQ-020 In IDLE, trig latches ch_mask, width, period and n_pulses; later input changes do not affect the running burst.
REQ-021 y0 is not latched; out = y0 XOR (active AND latched mask) in every cycle.
REQ-022 trig at edge T with width>0 and n_pulses>0: HIGH from edge T+1; out and busy assert at T+1.
REQ-023 HIGH lasts exactly width cycles, then LOW.
REQ-024 Effective period = max(period, width+1); next rising edge follows the previous one after exactly the effective period.
REQ-025 After the n_pulses-th HIGH: no trailing LOW gap; FSM goes to IDLE, done=1 for one cycle, busy=0 in that same cycle.
REQ-026 pulse_idx clears on an accepted trig and increments on each HIGH entry; it holds after the burst.
REQ-027 width==0 or n_pulses==0: out unchanged, busy stays 0, done pulses at T+1, pulse_idx=0.
REQ-028 trig while busy is ignored (counted in stat_drops when enabled).
REQ-029 abort in HIGH or LOW: IDLE at next edge, out returns to y0, done not asserted, pulse_idx holds.
REQ-030 abort and trig in the same IDLE cycle: trig is ignored.
REQ-031 Counters saturate at all-ones; they never wrap.

Reset
REQ-032 rst_n low asynchronously forces IDLE, busy=0, done=0, pulse_idx=0, stat counters=0, latched fields=0.
REQ-033 During reset out = y0 (mask cleared); a burst in progress is dropped with no done.
REQ-034 Reset release takes effect at the first clk edge with rst_n high.

Configuration
REQ-035 With macro AFE_PULSER_BURST_STATS_EN defined:
- stat_pulses counts every HIGH entry.
- stat_drops counts every ignored trig (REQ-028, REQ-030).
REQ-036 Without AFE_PULSER_BURST_STATS_EN: stat_pulses and stat_drops are tied to 0 and no counter logic is synthesised.

Verification
REQ-037 Basic burst: N_CH=4, y0=0, mask=4'b0101, width=3, period=5, n=2, trig at T -> out=0101 during T+1..T+3 and T+6..T+8, 0000 otherwise; done at T+9; pulse_idx=2.
REQ-038 Period clamp: width=4, period=2, n=3 -> rising edges 5 cycles apart; done 14 cycles after T+1.
REQ-039 Polarity and zero width: y0=4'b1111, mask=4'b0001, width=1, n=1 -> out=1110 for one cycle at T+1; width=0 -> out stays 1111, done at T+1.
REQ-040 Retrigger and abort: trig at T+2 of a burst -> ignored, stat_drops=1 (0 without macro); abort at T+4 -> out=y0 at T+5, no done.
REQ-041 Async reset mid-burst: rst_n low in HIGH -> out=y0, busy=0 immediately, without a clk edge; after release, a new trig runs a normal burst.
REQ-042 Saturation: n_pulses=255, width=1, period=2 -> pulse_idx=255, done at T+510; stat_pulses +255.

Source files
------------

// File: rtl/afe_pulser_burst_if.sv
// Control/status bundle for afe_pulser_burst: burst request fields in, pulse outputs and status out.
// The master drives the request side, the slave (the pulser) drives the outputs.
interface afe_pulser_burst_if #(
    parameter int N_CH   = 4,
    parameter int W_BITS = 16,
    parameter int N_BITS = 8
);
    logic              i_trig;
    logic              i_abort;
    logic [N_CH-1:0]   i_ch_mask;
    logic [N_CH-1:0]   i_y0;
    logic [W_BITS-1:0] i_width;
    logic [W_BITS-1:0] i_period;
    logic [N_BITS-1:0] i_n_pulses;
    logic [N_CH-1:0]   o_out;
    logic              o_busy;
    logic              o_done;
    logic [N_BITS-1:0] o_pulse_idx;
    logic [31:0]       o_stat_pulses;
    logic [15:0]       o_stat_drops;

    modport master (
        output i_trig, i_abort, i_ch_mask, i_y0, i_width, i_period, i_n_pulses,
        input  o_out, o_busy, o_done, o_pulse_idx, o_stat_pulses, o_stat_drops
    );

    modport slave (
        input  i_trig, i_abort, i_ch_mask, i_y0, i_width, i_period, i_n_pulses,
        output o_out, o_busy, o_done, o_pulse_idx, o_stat_pulses, o_stat_drops
    );
endinterface

// File: rtl/afe_pulser_burst.sv
// Multi-channel pulse-burst generator; a trig in IDLE starts the burst one cycle later, out = y0 ^ active mask.
// No backpressure: trig while busy (or together with abort) is dropped; AFE_PULSER_BURST_STATS_EN adds lifetime counters.
module afe_pulser_burst #(
    parameter int N_CH   = 4,
    parameter int W_BITS = 16,
    parameter int N_BITS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    afe_pulser_burst_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [W_BITS:0]   ONE_W = 1;
    localparam logic [N_BITS-1:0] ONE_N = 1;

    state_t            r_state;
    logic [N_CH-1:0]   r_mask;
    logic [N_CH-1:0]   r_act;
    logic [W_BITS-1:0] r_width;
    logic [W_BITS:0]   r_eff;
    logic [W_BITS:0]   r_cyc;
    logic [N_BITS-1:0] r_npulses;
    logic [N_BITS-1:0] r_pidx;
    logic              r_busy;
    logic              r_done;

    logic              w_accept;
    logic              w_zero;
    logic [W_BITS:0]   w_eff;

    assign w_accept = bus.i_trig && !bus.i_abort && (r_state == IDLE);
    assign w_zero   = (bus.i_width == '0) || (bus.i_n_pulses == '0);
    // One extra bit so a full-scale width still leaves a one-cycle low gap.
    assign w_eff    = ({1'b0, bus.i_period} > {1'b0, bus.i_width}) ? {1'b0, bus.i_period}
                                                                     : {1'b0, bus.i_width} + ONE_W;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_mask    <= '0;
            r_act     <= '0;
            r_width   <= '0;
            r_eff     <= '0;
            r_cyc     <= '0;
            r_npulses <= '0;
            r_pidx    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_mask    <= bus.i_ch_mask;
                        r_width   <= bus.i_width;
                        r_eff     <= w_eff;
                        r_npulses <= bus.i_n_pulses;
                        if (w_zero) begin
                            r_pidx <= '0;
                            r_done <= 1'b1;
                        end else begin
                            r_state <= HIGH;
                            r_busy  <= 1'b1;
                            r_act   <= bus.i_ch_mask;
                            r_cyc   <= ONE_W;
                            r_pidx  <= ONE_N;
                        end
                    end
                end
                HIGH: begin
                    if (bus.i_abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_act   <= '0;
                    end else if (r_cyc == {1'b0, r_width}) begin
                        r_act <= '0;
                        if (r_pidx == r_npulses) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= LOW;
                            r_cyc   <= r_cyc + ONE_W;
                        end
                    end else begin
                        r_cyc <= r_cyc + ONE_W;
                    end
                end
                LOW: begin
                    if (bus.i_abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_act   <= '0;
                    end else if (r_cyc == r_eff) begin
                        r_state <= HIGH;
                        r_act   <= r_mask;
                        r_cyc   <= ONE_W;
                        if (r_pidx != '1) begin
                            r_pidx <= r_pidx + ONE_N;
                        end
                    end else begin
                        r_cyc <= r_cyc + ONE_W;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // y0 is applied combinationally so polarity follows the input even during reset.
    assign bus.o_out       = bus.i_y0 ^ r_act;
    assign bus.o_busy      = r_busy;
    assign bus.o_done      = r_done;
    assign bus.o_pulse_idx = r_pidx;

`ifdef AFE_PULSER_BURST_STATS_EN
    logic        w_rise;
    logic        w_drop;
    logic [31:0] r_stat_pulses;
    logic [15:0] r_stat_drops;

    assign w_rise = (w_accept && !w_zero) ||
                    ((r_state == LOW) && (r_cyc == r_eff) && !bus.i_abort);
    assign w_drop = bus.i_trig && !w_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_pulses <= '0;
            r_stat_drops  <= '0;
        end else begin
            if (w_rise && (r_stat_pulses != '1)) begin
                r_stat_pulses <= r_stat_pulses + 32'd1;
            end
            if (w_drop && (r_stat_drops != '1)) begin
                r_stat_drops <= r_stat_drops + 16'd1;
            end
        end
    end

    assign bus.o_stat_pulses = r_stat_pulses;
    assign bus.o_stat_drops  = r_stat_drops;
`else
    assign bus.o_stat_pulses = '0;
    assign bus.o_stat_drops  = '0;
`endif
endmodule

// File: tb/tb_afe_pulser_burst.sv
// Randomized bench for afe_pulser_burst against a per-cycle waveform model derived from burst parameters.
module tb_afe_pulser_burst;
    localparam int N_CH   = 4;
    localparam int W_BITS = 16;
    localparam int N_BITS = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    afe_pulser_burst_if #(.N_CH(N_CH), .W_BITS(W_BITS), .N_BITS(N_BITS)) bus ();

    afe_pulser_burst #(.N_CH(N_CH), .W_BITS(W_BITS), .N_BITS(N_BITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int exp_pulses = 0;
    int exp_drops = 0;
    int last_idx = 0;

    function automatic int stat_exp(input int v);
`ifdef AFE_PULSER_BURST_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    // Runs one burst from an idle DUT and checks every cycle against the waveform model.
    task automatic run_burst(input logic [N_CH-1:0] m, input int w, input int p, input int n,
                             input int abort_at, input int retrig_at, input string tag);
        int eff, dlen, last, held, exp_idx;
        bit act, exp_busy, exp_done;
        logic [N_CH-1:0] exp_out;
        eff  = (p > w) ? p : w + 1;
        dlen = (w == 0 || n == 0) ? 1 : (n - 1) * eff + w + 1;
        last = (abort_at > 0) ? abort_at + 2 : dlen;
        held = (abort_at > 0) ? (abort_at - 1) / eff + 1 : n;

        @(posedge clk); #1;
        bus.i_trig = 1'b1; bus.i_abort = 1'b0; bus.i_ch_mask = m;
        bus.i_width = W_BITS'(w); bus.i_period = W_BITS'(p); bus.i_n_pulses = N_BITS'(n);
        bus.i_y0 = N_CH'($urandom);
        @(negedge clk);
        n_cmp++;
        if (bus.o_out !== bus.i_y0 || bus.o_busy !== 1'b0 || bus.o_pulse_idx !== N_BITS'(last_idx)) begin
            n_err++;
            $display("FAIL %s idle_before out=%h busy=%b idx=%0d required out=%h busy=0 idx=%0d",
                     tag, bus.o_out, bus.o_busy, bus.o_pulse_idx, bus.i_y0, last_idx);
        end

        for (int k = 1; k <= last; k++) begin
            @(posedge clk); #1;
            bus.i_trig = (k == retrig_at);
            bus.i_abort = (k == abort_at);
            bus.i_y0 = N_CH'($urandom);
            bus.i_ch_mask = N_CH'($urandom);
            bus.i_width = W_BITS'($urandom_range(0, 8));
            bus.i_period = W_BITS'($urandom_range(0, 12));
            bus.i_n_pulses = N_BITS'($urandom_range(0, 5));
            @(negedge clk);
            if (abort_at > 0 && k > abort_at) begin
                act = 0; exp_busy = 0; exp_done = 0; exp_idx = held;
            end else if (dlen == 1) begin
                act = 0; exp_busy = 0; exp_done = 1; exp_idx = 0;
            end else begin
                act      = (k < dlen) && (((k - 1) % eff) < w);
                exp_busy = (k < dlen);
                exp_done = (k == dlen);
                exp_idx  = (k < dlen) ? (k - 1) / eff + 1 : n;
            end
            exp_out = bus.i_y0 ^ (act ? m : '0);
            n_cmp++;
            if (bus.o_out !== exp_out) begin
                n_err++;
                $display("FAIL %s out k=%0d got=%h required=%h", tag, k, bus.o_out, exp_out);
            end
            n_cmp++;
            if (bus.o_busy !== exp_busy) begin
                n_err++;
                $display("FAIL %s busy k=%0d got=%b required=%b", tag, k, bus.o_busy, exp_busy);
            end
            n_cmp++;
            if (bus.o_done !== exp_done) begin
                n_err++;
                $display("FAIL %s done k=%0d got=%b required=%b", tag, k, bus.o_done, exp_done);
            end
            n_cmp++;
            if (bus.o_pulse_idx !== N_BITS'(exp_idx)) begin
                n_err++;
                $display("FAIL %s pulse_idx k=%0d got=%0d required=%0d", tag, k, bus.o_pulse_idx, exp_idx);
            end
        end
        bus.i_trig = 1'b0;
        bus.i_abort = 1'b0;
        if (dlen > 1) exp_pulses += held;
        last_idx = (dlen > 1) ? held : 0;
        if (retrig_at > 0) exp_drops++;
    endtask

    task automatic test_stats(input string tag);
        @(negedge clk);
        n_cmp++;
        if (bus.o_stat_pulses !== 32'(stat_exp(exp_pulses))) begin
            n_err++;
            $display("FAIL %s stat_pulses got=%0d required=%0d", tag, bus.o_stat_pulses, stat_exp(exp_pulses));
        end
        n_cmp++;
        if (bus.o_stat_drops !== 16'(stat_exp(exp_drops))) begin
            n_err++;
            $display("FAIL %s stat_drops got=%0d required=%0d", tag, bus.o_stat_drops, stat_exp(exp_drops));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_trig = 1'b0; bus.i_abort = 1'b0; bus.i_ch_mask = '0;
        bus.i_width = '0; bus.i_period = '0; bus.i_n_pulses = '0;
        bus.i_y0 = 4'b1010;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.o_out !== 4'b1010 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_pulse_idx !== '0) begin
            n_err++;
            $display("FAIL reset_state out=%h busy=%b done=%b idx=%0d required out=a busy=0 done=0 idx=0",
                     bus.o_out, bus.o_busy, bus.o_done, bus.o_pulse_idx);
        end
        rst_n = 1'b1;
        last_idx = 0;
        test_stats("reset");
    endtask

    task automatic test_abort_trig_idle();
        @(posedge clk); #1;
        bus.i_trig = 1'b1; bus.i_abort = 1'b1; bus.i_width = 16'd3; bus.i_n_pulses = 8'd2;
        bus.i_ch_mask = 4'b1111;
        @(posedge clk); #1;
        bus.i_trig = 1'b0; bus.i_abort = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_out !== bus.i_y0) begin
            n_err++;
            $display("FAIL abort_trig_idle busy=%b done=%b out=%h required busy=0 done=0 out=%h",
                     bus.o_busy, bus.o_done, bus.o_out, bus.i_y0);
        end
        exp_drops++;
        test_stats("abort_trig_idle");
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1;
        bus.i_trig = 1'b1; bus.i_ch_mask = 4'b1111; bus.i_width = 16'd10;
        bus.i_period = 16'd12; bus.i_n_pulses = 8'd3; bus.i_y0 = 4'b0110;
        @(posedge clk); #1;
        bus.i_trig = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.o_busy !== 1'b1 || bus.o_out !== 4'b1001) begin
            n_err++;
            $display("FAIL async_reset_pre busy=%b out=%h required busy=1 out=9", bus.o_busy, bus.o_out);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.o_out !== 4'b0110 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_pulse_idx !== '0) begin
            n_err++;
            $display("FAIL async_reset out=%h busy=%b done=%b idx=%0d required out=6 busy=0 done=0 idx=0",
                     bus.o_out, bus.o_busy, bus.o_done, bus.o_pulse_idx);
        end
        exp_pulses = 0; exp_drops = 0; last_idx = 0;
        @(negedge clk);
        n_cmp++;
        if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset_hold done=%b busy=%b required 0 0", bus.o_done, bus.o_busy);
        end
        rst_n = 1'b1;
        test_stats("async_reset");
        run_burst(4'b0011, 2, 4, 3, 0, 0, "after_reset");
    endtask

    task automatic test_random(input int iters);
        int w, p, n, eff, dlen, ab, rt;
        for (int i = 0; i < iters; i++) begin
            w = $urandom_range(0, 6);
            p = $urandom_range(0, 10);
            n = $urandom_range(0, 4);
            eff = (p > w) ? p : w + 1;
            dlen = (w == 0 || n == 0) ? 1 : (n - 1) * eff + w + 1;
            ab = (dlen > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, dlen - 1) : 0;
            rt = (dlen > 1 && $urandom_range(0, 1) == 0) ? $urandom_range(1, dlen - 1) : 0;
            if (ab > 0 && rt > ab) rt = 0;
            run_burst(N_CH'($urandom), w, p, n, ab, rt, "random");
        end
        test_stats("random");
    endtask

    initial begin
        test_reset();
        run_burst(4'b0101, 3, 5, 2, 0, 0, "basic");
        run_burst(4'b1100, 4, 2, 3, 0, 0, "period_clamp");
        run_burst(4'b0001, 1, 3, 1, 0, 0, "polarity_w1");
        run_burst(4'b0001, 0, 3, 1, 0, 0, "zero_width");
        run_burst(4'b1111, 3, 5, 0, 0, 0, "zero_count");
        test_stats("directed");
        run_burst(4'b1011, 3, 5, 2, 4, 2, "retrig_abort");
        test_stats("retrig_abort");
        test_abort_trig_idle();
        test_async_reset();
        run_burst(4'b0110, 1, 2, 255, 0, 0, "saturation");
        test_stats("saturation");
        test_random(10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
